// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator / tone detector pair.
package tone_pkg;

  localparam int unsigned TONE_CLK_HZ_DEF  = 25_000_000;
  localparam int unsigned TONE_TONE_HZ_DEF = 560;

  // Nominal half-period in clocks; both ends of the link use this so they agree.
  function automatic int unsigned half_of(input int unsigned clk_hz,
                                          input int unsigned tone_hz);
    return clk_hz / tone_hz / 2;
  endfunction

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } tone_state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus a third flop for any-edge detection on a pin.
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic edge_c
);

  logic s1, s2, s3;

  // Synchronizer chain; s3 holds the previous synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign edge_c = s2 ^ s3;

endmodule

// File: rtl/tone_detector.sv
// Measures the half-period of a square-wave pin and flags a locked tone.
module tone_detector
  import tone_pkg::*;
#(
  parameter int unsigned CLK_HZ   = TONE_CLK_HZ_DEF,
  parameter int unsigned TONE_HZ  = TONE_TONE_HZ_DEF,
  parameter int unsigned HALF     = half_of(CLK_HZ, TONE_HZ),
  parameter int unsigned TOL      = 256,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned CW       = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tone_in,
  output logic          present,
  output logic [CW-1:0] half_period,
  output logic          meas_valid,
  output logic          miss
);

  localparam int unsigned MW = $clog2(LOCK_CNT + 1);
  localparam logic [CW-1:0] WIN_LO    = CW'(HALF - TOL);
  localparam logic [CW-1:0] WIN_HI    = CW'(HALF + TOL);
  localparam logic [MW-1:0] MATCH_MAX = MW'(LOCK_CNT);

  // Elaboration-time parameter sanity.
  if (HALF < TOL) begin : g_bad_tol
    $error("tone_detector: HALF-TOL underflows");
  end
  if ((64'(HALF) + 64'(TOL) + 64'd1) >= (64'd1 << CW)) begin : g_bad_cw
    $error("tone_detector: CW too narrow for HALF+TOL+1");
  end

  tone_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [MW-1:0] match_q, match_d;
  logic [CW-1:0] half_d;
  logic          mv_d, miss_d, present_d;
  logic          edge_c, in_win_c, timeout_c;

  sync_edge u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .din    (tone_in),
    .edge_c (edge_c)
  );

  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign in_win_c  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
  assign timeout_c = (cnt_q > WIN_HI);

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      match_q     <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      miss        <= 1'b0;
      present     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      half_period <= half_d;
      meas_valid  <= mv_d;
      miss        <= miss_d;
      present     <= present_d;
    end
  end

  // Next state: an edge always beats a timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    match_d = match_q;
    half_d  = half_period;
    mv_d    = 1'b0;
    miss_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        match_d = '0;
        if (edge_c) begin
          state_d = MEASURE;
          cnt_d   = CW'(1);
        end
      end
      MEASURE, LOCKED: begin
        if (edge_c) begin
          half_d = cnt_q;
          mv_d   = 1'b1;
          cnt_d  = CW'(1);
          if (in_win_c) begin
            if (match_q != MATCH_MAX) match_d = match_q + MW'(1);
            if (match_d == MATCH_MAX) state_d = LOCKED;
          end else begin
            match_d = '0;
            miss_d  = 1'b1;
            state_d = MEASURE;
          end
        end else if (timeout_c) begin
          match_d = '0;
          miss_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        match_d = '0;
      end
    endcase
    present_d = (state_d == LOCKED);
  end

endmodule

// File: tb/tb_tone_detector.sv
// Self-checking bench for tone_detector, scaled down to HALF=50, TOL=8.
module tb_tone_detector;

  localparam int unsigned CW = 12;
  localparam int LO = 42;   // HALF - TOL
  localparam int HI = 58;   // HALF + TOL
  localparam int L  = 8;    // LOCK_CNT

  logic          clk = 1'b0;
  logic          rst_n;
  logic          tone_in;
  logic          present;
  logic [CW-1:0] half_period;
  logic          meas_valid;
  logic          miss;

  tone_detector #(
    .CLK_HZ   (56000),
    .TONE_HZ  (560),
    .TOL      (8),
    .LOCK_CNT (8),
    .CW       (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tone_in     (tone_in),
    .present     (present),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .miss        (miss)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int got_meas[$];
  int got_miss = 0;
  int ivq[$];

  typedef struct {
    int period;
    int n_edges;
    int exp_present;
    int exp_meas;
    int exp_miss;
  } vec_t;

  vec_t vt[10];

  // Event monitor: records every measurement and miss pulse.
  always @(negedge clk) begin
    if (meas_valid) got_meas.push_back(int'(half_period));
    if (miss) got_miss++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic toggle();
    tone_in = ~tone_in;
  endtask

  // Drive one toggle then one toggle per queued interval; return present, then let it time out.
  task automatic drive_seq(output int pres);
    got_meas.delete();
    got_miss = 0;
    @(negedge clk);
    toggle();
    foreach (ivq[i]) begin
      repeat (ivq[i]) @(negedge clk);
      toggle();
    end
    repeat (4) @(negedge clk);
    pres = int'(present);
    repeat (HI + 30) @(negedge clk);
  endtask

  initial begin
    int pres, w, emiss, st, m, ok;
    int exp_meas[$];

    vt[0] = '{50, 10, 1,  9,  1};
    vt[1] = '{42, 10, 1,  9,  1};
    vt[2] = '{58, 10, 1,  9,  1};
    vt[3] = '{41, 10, 0,  9, 10};
    vt[4] = '{59, 10, 0,  9, 10};
    vt[5] = '{25, 20, 0, 19, 20};
    vt[6] = '{50,  9, 1,  8,  1};
    vt[7] = '{50,  8, 0,  7,  1};
    vt[8] = '{70,  5, 0,  0,  5};
    vt[9] = '{60,  4, 0,  0,  4};

    rst_n   = 1'b0;
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_present", int'(present), 0);
    check("rst_half", int'(half_period), 0);
    check("rst_mv", int'(meas_valid), 0);
    check("rst_miss", int'(miss), 0);
    rst_n = 1'b1;

    // Quiet input: nothing must happen.
    got_meas.delete();
    got_miss = 0;
    repeat (2000) @(negedge clk);
    check("quiet_present", int'(present), 0);
    check("quiet_meas", got_meas.size(), 0);
    check("quiet_miss", got_miss, 0);

    // Lock timing: present comes up with the 8th in-window measurement.
    @(negedge clk);
    toggle();
    for (int i = 1; i <= 8; i++) begin
      repeat (i == 1 ? 50 : 47) @(negedge clk);
      toggle();
      repeat (3) @(negedge clk);
      check("lock_mv", int'(meas_valid), 1);
      check("lock_half", int'(half_period), 50);
      check("lock_present", int'(present), (i >= L) ? 1 : 0);
    end
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!miss && w < 200);
    check("timeout_delay", w, HI + 1);
    check("timeout_present", int'(present), 0);
    @(negedge clk);
    check("timeout_single", int'(miss), 0);
    check("timeout_quiet_mv", int'(meas_valid), 0);

    // Table of steady tones, each ending in a tone-stopped timeout.
    for (int v = 0; v < 10; v++) begin
      ivq.delete();
      for (int e = 1; e < vt[v].n_edges; e++) ivq.push_back(vt[v].period);
      drive_seq(pres);
      check($sformatf("vec%0d_present", v), pres, vt[v].exp_present);
      check($sformatf("vec%0d_meas", v), got_meas.size(), vt[v].exp_meas);
      check($sformatf("vec%0d_miss", v), got_miss, vt[v].exp_miss);
      ok = 1;
      foreach (got_meas[i]) if (got_meas[i] != vt[v].period) ok = 0;
      check($sformatf("vec%0d_values", v), ok, 1);
    end

    // Reset while locked: async clear, no miss, then a full relock.
    got_miss = 0;
    @(negedge clk);
    toggle();
    for (int i = 0; i < 8; i++) begin
      repeat (50) @(negedge clk);
      toggle();
    end
    repeat (10) @(negedge clk);
    check("prereset_present", int'(present), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_present", int'(present), 0);
    check("async_half", int'(half_period), 0);
    check("async_mv", int'(meas_valid), 0);
    check("async_miss", int'(miss), 0);
    tone_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got_miss = 0;
    got_meas.delete();
    repeat (5) @(negedge clk);
    check("postreset_miss", got_miss, 0);
    toggle();
    for (int i = 0; i < 7; i++) begin
      repeat (50) @(negedge clk);
      toggle();
    end
    repeat (5) @(negedge clk);
    check("relock_8_edges", int'(present), 0);
    repeat (45) @(negedge clk);
    toggle();
    repeat (4) @(negedge clk);
    check("relock_9_edges", int'(present), 1);
    repeat (HI + 30) @(negedge clk);
    check("relock_idle", int'(present), 0);

    // Random interval sequences against an event-level model.
    for (int s = 0; s < 25; s++) begin
      int r;
      ivq.delete();
      r = int'($urandom_range(1, 13));
      for (int e = 0; e < r; e++) begin
        int k;
        k = int'($urandom_range(0, 9));
        if (k < 6)      ivq.push_back(int'($urandom_range(40, 60)));
        else if (k < 8) ivq.push_back(int'($urandom_range(57, 64)));
        else            ivq.push_back(int'($urandom_range(1, 30)));
      end
      exp_meas.delete();
      emiss = 0;
      m = 0;
      st = 1;
      foreach (ivq[i]) begin
        if (ivq[i] > HI + 1) begin
          emiss++;
          m = 0;
          st = 1;
        end else begin
          exp_meas.push_back(ivq[i]);
          if (ivq[i] >= LO && ivq[i] <= HI) begin
            if (m < L) m++;
            if (m == L) st = 2;
          end else begin
            emiss++;
            m = 0;
            st = 1;
          end
        end
      end
      emiss++;
      drive_seq(pres);
      check($sformatf("rnd%0d_present", s), pres, (st == 2) ? 1 : 0);
      check($sformatf("rnd%0d_meas", s), got_meas.size(), exp_meas.size());
      check($sformatf("rnd%0d_miss", s), got_miss, emiss);
      ok = (got_meas.size() == exp_meas.size()) ? 1 : 0;
      if (ok == 1) foreach (got_meas[i]) if (got_meas[i] != exp_meas[i]) ok = 0;
      check($sformatf("rnd%0d_values", s), ok, 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
